uart_cmd_interface: RTL and testbench

Byte-oriented command decoder between the UART receiver/transmitter and the ALU, generalised to multi-byte operands. Host sends an opcode byte, then operand bytes LSB-first; operands are committed atomically once complete. Results go back as multi-byte frames, paced by the transmitter's done handshake. An inter-byte timeout aborts stalled loads with an error byte.

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/rx_timeout_counter.sv | 33 +++
 rtl/uart_cmd_interface.sv | 192 +++++++++++++++++++
 tb/tb_uart_cmd_interface.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, error bytes and FSM encoding for the UART command decoder.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SEND    = 2'd2,
    ST_WAIT_TX = 2'd3
  } state_t;

  localparam logic [7:0] OP_LOAD_A     = 8'h00;
  localparam logic [7:0] OP_LOAD_B     = 8'h01;
  localparam logic [7:0] OP_GET_RESULT = 8'h02;
  localparam logic [7:0] OP_LOAD_OP    = 8'h03;

  localparam logic [7:0] ERR_UNKNOWN_OP = 8'hFF;
  localparam logic [7:0] ERR_TIMEOUT    = 8'hFE;

  function automatic logic is_load_opcode(input logic [7:0] op);
    return (op == OP_LOAD_A) || (op == OP_LOAD_B) || (op == OP_LOAD_OP);
  endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Idle-cycle counter for operand loads; expired pulses once the limit is hit.
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_count
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] count_reg;

      // Saturates at LAST so a held enable cannot wrap and re-arm.
      always_ff @(posedge i_clk) begin
        if (i_reset || clear) begin
          count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      assign expired = enable && !clear && (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/uart_cmd_interface.sv
// Byte command decoder between UART and ALU: multi-byte operand loads with
// atomic commit, multi-byte result frames paced by tx done, load timeout.
module uart_cmd_interface
  import uart_cmd_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_ALU_OP      = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_alu_data_out,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  output logic [NB_DATA-1:0]   o_alu_data_A,
  output logic [NB_DATA-1:0]   o_alu_data_B,
  output logic [NB_ALU_OP-1:0] o_alu_op,
  output logic                 o_busy
);

  localparam int N_BYTES = NB_DATA / 8;
  localparam logic [2:0] LAST_BYTE = 3'(N_BYTES - 1);

  state_t state_reg, state_next;
  logic [7:0]           opcode_reg, opcode_next;
  logic [2:0]           count_reg, count_next;
  logic [2:0]           idx_reg, idx_next;
  logic [2:0]           last_idx_reg, last_idx_next;
  logic [NB_DATA-1:0]   shadow_reg, shadow_next;
  logic [NB_DATA-1:0]   frame_reg, frame_next;
  logic [NB_DATA-1:0]   alu_a_reg, alu_a_next;
  logic [NB_DATA-1:0]   alu_b_reg, alu_b_next;
  logic [NB_ALU_OP-1:0] alu_op_reg, alu_op_next;
  logic [7:0]           tx_data_reg, tx_data_next;
  logic                 tx_start_reg, tx_start_next;
  logic                 busy_reg, busy_next;

  logic [NB_DATA-1:0] shadow_upd;
  logic [7:0]         frame_byte [8];
  logic               last_byte;
  logic               timeout_expired;

  // Shadow with the incoming byte dropped into slot count_reg.
  genvar gi;
  generate
    for (gi = 0; gi < N_BYTES; gi++) begin : g_shadow
      assign shadow_upd[8*gi +: 8] = (count_reg == 3'(gi)) ? i_rx_data : shadow_reg[8*gi +: 8];
    end
    for (gi = 0; gi < 8; gi++) begin : g_frame
      if (gi < N_BYTES) begin : g_used
        assign frame_byte[gi] = frame_reg[8*gi +: 8];
      end else begin : g_unused
        assign frame_byte[gi] = 8'h00;
      end
    end
  endgenerate

  assign last_byte = (opcode_reg == OP_LOAD_OP) ? (count_reg == 3'd0) : (count_reg == LAST_BYTE);

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   ((state_reg != ST_LOAD) || i_rx_done),
    .enable  (state_reg == ST_LOAD),
    .expired (timeout_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      opcode_reg   <= '0;
      count_reg    <= '0;
      idx_reg      <= '0;
      last_idx_reg <= '0;
      shadow_reg   <= '0;
      frame_reg    <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_op_reg   <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      opcode_reg   <= opcode_next;
      count_reg    <= count_next;
      idx_reg      <= idx_next;
      last_idx_reg <= last_idx_next;
      shadow_reg   <= shadow_next;
      frame_reg    <= frame_next;
      alu_a_reg    <= alu_a_next;
      alu_b_reg    <= alu_b_next;
      alu_op_reg   <= alu_op_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_rx_done) state_next = is_load_opcode(i_rx_data) ? ST_LOAD : ST_SEND;
      end
      ST_LOAD: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (i_rx_done) begin
          if (last_byte) state_next = ST_IDLE;
        end else if (timeout_expired) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) state_next = (idx_reg == last_idx_reg) ? ST_IDLE : ST_SEND;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    opcode_next   = opcode_reg;
    count_next    = count_reg;
    idx_next      = idx_reg;
    last_idx_next = last_idx_reg;
    shadow_next   = shadow_reg;
    frame_next    = frame_reg;
    alu_a_next    = alu_a_reg;
    alu_b_next    = alu_b_reg;
    alu_op_next   = alu_op_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    busy_next     = (state_next != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (i_rx_done) begin
          opcode_next   = i_rx_data;
          count_next    = '0;
          idx_next      = '0;
          shadow_next   = '0;
          last_idx_next = '0;
          if (i_rx_data == OP_GET_RESULT) begin
            frame_next    = i_alu_data_out;
            last_idx_next = LAST_BYTE;
          end else if (!is_load_opcode(i_rx_data)) begin
            frame_next = NB_DATA'(ERR_UNKNOWN_OP);
          end
        end
      end
      ST_LOAD: begin
        if (i_rx_done) begin
          shadow_next = shadow_upd;
          count_next  = count_reg + 3'd1;
          if (last_byte) begin
            case (opcode_reg)
              OP_LOAD_A: alu_a_next  = shadow_upd;
              OP_LOAD_B: alu_b_next  = shadow_upd;
              default:   alu_op_next = shadow_upd[NB_ALU_OP-1:0];
            endcase
          end
        end else if (timeout_expired) begin
          shadow_next   = '0;
          frame_next    = NB_DATA'(ERR_TIMEOUT);
          idx_next      = '0;
          last_idx_next = '0;
        end
      end
      ST_SEND: begin
        tx_data_next  = frame_byte[idx_reg];
        tx_start_next = 1'b1;
      end
      ST_WAIT_TX: begin
        if (i_tx_done && (idx_reg != last_idx_reg)) idx_next = idx_reg + 3'd1;
      end
      default: ;
    endcase
  end

  assign o_tx_data    = tx_data_reg;
  assign o_tx_start   = tx_start_reg;
  assign o_alu_data_A = alu_a_reg;
  assign o_alu_data_B = alu_b_reg;
  assign o_alu_op     = alu_op_reg;
  assign o_busy       = busy_reg;

endmodule

// File: tb/tb_uart_cmd_interface.sv
// Scoreboard bench for uart_cmd_interface (16-bit operands, 50-cycle timeout).
module tb_uart_cmd_interface;

  localparam int NB_DATA   = 16;
  localparam int NB_ALU_OP = 6;
  localparam int TIMEOUT   = 50;
  localparam int TX_LAT    = 3;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_rx_done = 1'b0;
  logic [7:0]           i_rx_data = 8'h00;
  logic                 i_tx_done = 1'b0;
  logic [NB_DATA-1:0]   i_alu_data_out = '0;
  logic [7:0]           o_tx_data;
  logic                 o_tx_start;
  logic [NB_DATA-1:0]   o_alu_data_A;
  logic [NB_DATA-1:0]   o_alu_data_B;
  logic [NB_ALU_OP-1:0] o_alu_op;
  logic                 o_busy;

  uart_cmd_interface #(
    .NB_DATA(NB_DATA),
    .NB_ALU_OP(NB_ALU_OP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data),
    .i_tx_done(i_tx_done),
    .i_alu_data_out(i_alu_data_out),
    .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start),
    .o_alu_data_A(o_alu_data_A),
    .o_alu_data_B(o_alu_data_B),
    .o_alu_op(o_alu_op),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Expected tx byte plus its start time relative to the last rx or tx done.
  typedef struct {
    logic [7:0] data;
    bit         ref_rx;
    int         delay;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int last_done_cyc = 0;
  bit mon_en = 1'b0;
  bit tx_auto = 1'b1;
  bit man_done = 1'b0;
  bit prev_start = 1'b0;
  logic [NB_DATA-1:0]   exp_a = '0;
  logic [NB_DATA-1:0]   exp_b = '0;
  logic [NB_ALU_OP-1:0] exp_op = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Monitor: operand outputs every cycle, tx bytes against the scoreboard.
  always @(negedge i_clk) begin
    if (mon_en && !i_reset) begin
      if (i_rx_done) last_rx_cyc = cyc;
      if (i_tx_done) last_done_cyc = cyc;
      chk("alu_a", o_alu_data_A, exp_a);
      chk("alu_b", o_alu_data_B, exp_b);
      chk("alu_op", o_alu_op, exp_op);
      if (prev_start) chk("start_width", o_tx_start, 0);
      if (o_tx_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got tx byte %02h, required no o_tx_start (cycle %0d)", o_tx_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_byte", o_tx_data, mon_e.data);
          chk("tx_timing", cyc - (mon_e.ref_rx ? last_rx_cyc : last_done_cyc), mon_e.delay);
          $display("tx byte %02h at cycle %0d", o_tx_data, cyc);
        end
      end
    end
    prev_start = (o_tx_start === 1'b1);
  end

  // Transmitter model: answers each start with a done pulse, or a manual pulse.
  initial forever begin
    @(negedge i_clk);
    if ((tx_auto && o_tx_start === 1'b1) || man_done) begin
      man_done = 1'b0;
      repeat (TX_LAT) @(posedge i_clk);
      #1 i_tx_done = 1'b1;
      @(posedge i_clk);
      #1 i_tx_done = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge i_clk);
      #1;
    end
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_done = 1'b0;
    $display("rx byte %02h at cycle %0d", b, cyc - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((o_busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_idle: got busy=%0b pending=%0d after %0d cycles, required idle", name, o_busy, exp_q.size(), n);
      exp_q.delete();
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    i_reset = 1'b0;
    mon_en = 1'b1;
    chk("reset_tx_start", o_tx_start, 0);
    chk("reset_tx_data", o_tx_data, 0);
    chk("reset_busy", o_busy, 0);

    send_byte(8'h00, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    exp_a = 16'h1234;
    idle(3);
    send_byte(8'h01, 0); send_byte(8'hCD, 0); send_byte(8'hAB, 0);
    exp_b = 16'hABCD;
    idle(3);
    send_byte(8'h03, 0); send_byte(8'hE5, 0);
    exp_op = 6'h25;
    idle(3);

    // Result frame, snapshot held while ALU changes; stray rx byte dropped.
    i_alu_data_out = 16'hBEEF;
    exp_q.push_back('{8'hEF, 1'b1, 2});
    exp_q.push_back('{8'hBE, 1'b0, 2});
    send_byte(8'h02, 0);
    idle(2);
    i_alu_data_out = 16'h0000;
    send_byte(8'h00, 0);
    wait_idle("get_result");
    man_done = 1'b1;
    idle(8);
    chk("busy_after_stray_done", o_busy, 0);
    send_byte(8'h03, 0); send_byte(8'h0A, 0);
    exp_op = 6'h0A;
    idle(3);

    exp_q.push_back('{8'hFF, 1'b1, 2});
    send_byte(8'h07, 0);
    chk("busy_unknown_op", o_busy, 1);
    wait_idle("unknown_op");
    chk("busy_after_error", o_busy, 0);

    // Partial load times out; A keeps 0x1234.
    send_byte(8'h00, 0);
    exp_q.push_back('{8'hFE, 1'b1, TIMEOUT + 2});
    send_byte(8'h11, 0);
    wait_idle("timeout");

    // Byte lands exactly on the expiry cycle and wins.
    send_byte(8'h01, 0);
    send_byte(8'h77, TIMEOUT - 1);
    send_byte(8'h66, 0);
    exp_b = 16'h6677;
    idle(TIMEOUT + 10);

    // Reset while waiting for tx done abandons the frame.
    tx_auto = 1'b0;
    i_alu_data_out = 16'h1357;
    exp_q.push_back('{8'h57, 1'b1, 2});
    send_byte(8'h02, 0);
    idle(5);
    chk("busy_wait_tx", o_busy, 1);
    i_reset = 1'b1;
    exp_a = '0;
    exp_b = '0;
    exp_op = '0;
    idle(1);
    i_reset = 1'b0;
    chk("post_reset_tx_start", o_tx_start, 0);
    chk("post_reset_tx_data", o_tx_data, 0);
    chk("post_reset_busy", o_busy, 0);
    idle(20);
    tx_auto = 1'b1;
    i_alu_data_out = 16'h2468;
    exp_q.push_back('{8'h68, 1'b1, 2});
    exp_q.push_back('{8'h24, 1'b0, 2});
    send_byte(8'h02, 0);
    wait_idle("get_after_reset");

    chk("pending_frames", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
